id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register for the 5-stage RV32I core. Captures the main-decoder control bundle and the
//  decode-stage operands on each clock and presents them to EX one cycle later.
//  Detects load-use hazards and drives stall_f/stall_d back to IF and ID.
//  Inserts a bubble on a load-use stall or on a branch/jump flush from EX.
//  Keeps a saturating count of inserted load-use bubbles for performance monitoring.
// PARAMETERS
//  XLEN     32  datapath width (PC, register data, immediate)
//  CNT_W    16  width of bubble_cnt
// PORTS
//  clk         in   1     rising-edge clock; single clock domain
//  rst         in   1     synchronous, active-high reset
//  flush_e     in   1     EX resolved taken branch/jal/jalr; kill the instruction now in ID
//  valid_d     in   1     ID holds a real instruction (0 = bubble from IF/ID)
//  regwr_d     in   1     register write enable (decoder regwr_sgn)
//  result_d    in   2     writeback select: 00 ALU, 01 memory, 10 PC+4 (decoder result_sgn)
//  memwr_d     in   1     memory write enable
//  alusrc_d    in   1     ALU B operand select: 1 = immediate
//  aluop_d     in   2     ALU op class to the ALU decoder
//  branch_d    in   1     conditional branch
//  jump_d      in   1     jal
//  jalr_d      in   1     jalr
//  func3_d     in   3     instr[14:12]
//  func7b5_d   in   1     instr[30]
//  rd1_d       in   XLEN  register-file read data for rs1
//  rd2_d       in   XLEN  register-file read data for rs2
//  pc_d        in   XLEN  PC of the instruction in ID
//  pcplus4_d   in   XLEN  pc_d + 4
//  imm_d       in   XLEN  sign-extended immediate
//  rs1_d       in   5     source register 1 index
//  rs2_d       in   5     source register 2 index
//  rd_d        in   5     destination register index
//  <x>_e       out  same  registered copy of every <x>_d above, including valid_e
//  stall_f     out  1     hold PC (combinational)
//  stall_d     out  1     hold IF/ID register (combinational)
//  bubble_cnt  out  CNT_W saturating count of load-use bubbles
// BEHAVIOUR
//  Reset:
//   - When rst=1 at a clock edge, every *_e output and bubble_cnt become 0. rst has priority over all else.
//   - stall_f and stall_d are 0 while valid_e=0, including immediately after reset.
//  Hazard detection (combinational):
//   - lu = valid_e & regwr_e & (result_e==2'b01) & (rd_e!=0) & valid_d & (rd_e==rs1_d | rd_e==rs2_d).
//   - stall_f = stall_d = lu & ~flush_e.
//   - rs fields are compared for every opcode, so spurious stalls on lui/auipc/jal are accepted.
//  Register update, priority order, at each rising edge:
//   1) rst: clear all.
//   2) flush_e | lu: bubble. All control outputs, valid_e and all data/index outputs load 0.
//   3) Otherwise: every *_e loads the matching *_d; valid_e loads valid_d.
//  Latency: exactly 1 cycle from ID to EX. No back-pressure into this register.
//   - During a stall, ID and IF hold externally, and the held instruction re-enters on the next edge.
//  flush_e and lu in the same cycle: a single bubble is inserted; no stall is issued; bubble_cnt does not increment.
//  bubble_cnt: +1 on each edge where lu & ~flush_e & ~rst.
//   - Saturates at 2^CNT_W-1; never wraps.
//  Back-to-back loads: a load stalled behind a load advances after exactly one bubble.
// TESTING
//  1) rst=1 for 2 cycles with random *_d -> all *_e=0, valid_e=0, stall_f=stall_d=0, bubble_cnt=0.
//  2) add x5 (regwr=1,result=00,rd=5) then sub using rs1=5 -> no stall; sub appears in EX one cycle after add.
//  3) lw x5 in EX, add rs2=5 in ID -> stall_f=stall_d=1 for 1 cycle; next EX is a bubble, then the add.
//     bubble_cnt=1.
//  4) lw x0 in EX, add rs1=0 in ID -> no stall. Load into rd=5 with valid_d=0 in ID -> no stall.
//  5) lu condition and flush_e=1 in the same cycle -> stall outputs 0, next EX is a bubble, bubble_cnt unchanged.
//  6) Force bubble_cnt to 16'hFFFF via repeated load-use pairs (or CNT_W=2) -> count holds at max; no wrap.
//     Assert rst mid-stall -> everything cleared next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core: carries the decoded control bundle and operands
// into EX, detects load-use hazards, inserts bubbles and counts load-use bubbles.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic             regwr_d,
    input  logic [1:0]       result_d,
    input  logic             memwr_d,
    input  logic             alusrc_d,
    input  logic [1:0]       aluop_d,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             jalr_d,
    input  logic [2:0]       func3_d,
    input  logic             func7b5_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pcplus4_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    output logic             valid_e,
    output logic             regwr_e,
    output logic [1:0]       result_e,
    output logic             memwr_e,
    output logic             alusrc_e,
    output logic [1:0]       aluop_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic             jalr_e,
    output logic [2:0]       func3_e,
    output logic             func7b5_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pcplus4_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] RESULT_MEM = 2'b01;

    typedef struct packed {
        logic            valid;
        logic            regwr;
        logic [1:0]      result;
        logic            memwr;
        logic            alusrc;
        logic [1:0]      aluop;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [2:0]      func3;
        logic            func7b5;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_bundle_t;

    ex_bundle_t       id_bundle;
    ex_bundle_t       ex_d, ex_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             lu;

    assign id_bundle = '{
        valid:   valid_d,
        regwr:   regwr_d,
        result:  result_d,
        memwr:   memwr_d,
        alusrc:  alusrc_d,
        aluop:   aluop_d,
        branch:  branch_d,
        jump:    jump_d,
        jalr:    jalr_d,
        func3:   func3_d,
        func7b5: func7b5_d,
        rd1:     rd1_d,
        rd2:     rd2_d,
        pc:      pc_d,
        pcplus4: pcplus4_d,
        imm:     imm_d,
        rs1:     rs1_d,
        rs2:     rs2_d,
        rd:      rd_d
    };

    // rs fields are compared regardless of opcode; spurious stalls on lui/auipc/jal are harmless.
    assign lu = ex_q.valid & ex_q.regwr & (ex_q.result == RESULT_MEM) & (ex_q.rd != 5'd0)
              & valid_d & ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d));

    // A flush already kills the dependent instruction, so no stall is needed alongside it.
    assign stall_f = lu & ~flush_e;
    assign stall_d = lu & ~flush_e;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_d         = id_bundle;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_e || lu) begin
            ex_d = '0;
        end
        if (lu && !flush_e && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_e    = ex_q.valid;
    assign regwr_e    = ex_q.regwr;
    assign result_e   = ex_q.result;
    assign memwr_e    = ex_q.memwr;
    assign alusrc_e   = ex_q.alusrc;
    assign aluop_e    = ex_q.aluop;
    assign branch_e   = ex_q.branch;
    assign jump_e     = ex_q.jump;
    assign jalr_e     = ex_q.jalr;
    assign func3_e    = ex_q.func3;
    assign func7b5_e  = ex_q.func7b5;
    assign rd1_e      = ex_q.rd1;
    assign rd2_e      = ex_q.rd2;
    assign pc_e       = ex_q.pc;
    assign pcplus4_e  = ex_q.pcplus4;
    assign imm_e      = ex_q.imm;
    assign rs1_e      = ex_q.rs1;
    assign rs2_e      = ex_q.rs2;
    assign rd_e       = ex_q.rd;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard scenarios plus randomized traffic,
// checked against a behavioural model of the ID->EX hand-off and the bubble counter.
module tb_id_ex_pipe_reg;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            valid;
        logic            regwr;
        logic [1:0]      result;
        logic            memwr;
        logic            alusrc;
        logic [1:0]      aluop;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [2:0]      func3;
        logic            func7b5;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_e = 1'b0;
    bundle_t din = '0;
    bundle_t obs;

    logic             valid_e, regwr_e, memwr_e, alusrc_e, branch_e, jump_e, jalr_e, func7b5_e;
    logic [1:0]       result_e, aluop_e;
    logic [2:0]       func3_e;
    logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, pcplus4_e, imm_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic             stall_f, stall_d;
    logic [CNT_W-1:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_e(flush_e),
        .valid_d(din.valid), .regwr_d(din.regwr), .result_d(din.result), .memwr_d(din.memwr),
        .alusrc_d(din.alusrc), .aluop_d(din.aluop), .branch_d(din.branch), .jump_d(din.jump),
        .jalr_d(din.jalr), .func3_d(din.func3), .func7b5_d(din.func7b5),
        .rd1_d(din.rd1), .rd2_d(din.rd2), .pc_d(din.pc), .pcplus4_d(din.pcplus4), .imm_d(din.imm),
        .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
        .valid_e(valid_e), .regwr_e(regwr_e), .result_e(result_e), .memwr_e(memwr_e),
        .alusrc_e(alusrc_e), .aluop_e(aluop_e), .branch_e(branch_e), .jump_e(jump_e),
        .jalr_e(jalr_e), .func3_e(func3_e), .func7b5_e(func7b5_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .imm_e(imm_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_cnt(bubble_cnt)
    );

    assign obs = {valid_e, regwr_e, result_e, memwr_e, alusrc_e, aluop_e, branch_e, jump_e, jalr_e,
                  func3_e, func7b5_e, rd1_e, rd2_e, pc_e, pcplus4_e, imm_e, rs1_e, rs2_e, rd_e};

    // Reference state: what EX should hold, and the expected bubble count.
    bundle_t exp_e = '0;
    int      exp_cnt = 0;
    bit      model_known = 1'b0;
    int      errors = 0;
    int      checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd6;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.valid   = ($urandom_range(0, 7) != 0);
        b.regwr   = 1'($urandom);
        b.result  = 2'($urandom);
        b.memwr   = 1'($urandom);
        b.alusrc  = 1'($urandom);
        b.aluop   = 2'($urandom);
        b.branch  = 1'($urandom);
        b.jump    = 1'($urandom);
        b.jalr    = 1'($urandom);
        b.func3   = 3'($urandom);
        b.func7b5 = 1'($urandom);
        b.rd1     = $urandom;
        b.rd2     = $urandom;
        b.pc      = $urandom & 32'hFFFF_FFFC;
        b.pcplus4 = b.pc + 32'd4;
        b.imm     = $urandom;
        b.rs1     = pick_reg();
        b.rs2     = pick_reg();
        b.rd      = pick_reg();
        return b;
    endfunction

    // A valid instruction with the given register usage and random payload.
    function automatic bundle_t instr(input logic regwr, input logic [1:0] result,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd);
        bundle_t b;
        b        = rand_bundle();
        b.valid  = 1'b1;
        b.regwr  = regwr;
        b.result = result;
        b.rs1    = rs1;
        b.rs2    = rs2;
        b.rd     = rd;
        return b;
    endfunction

    // One clock: check combinational stalls, advance the model, then check registered outputs.
    task automatic cycle();
        bit      hazard;
        bit      stall_exp;
        bundle_t nxt;
        int      nxt_cnt;
        #1;
        hazard = exp_e.valid && exp_e.regwr && exp_e.result == 2'b01 && exp_e.rd != 0 &&
                 din.valid && (exp_e.rd == din.rs1 || exp_e.rd == din.rs2);
        stall_exp = hazard && !flush_e;
        if (model_known) begin
            check("stall_f", stall_f, stall_exp);
            check("stall_d", stall_d, stall_exp);
        end
        if (rst) begin
            nxt     = '0;
            nxt_cnt = 0;
        end else begin
            nxt     = (hazard || flush_e) ? bundle_t'('0) : din;
            nxt_cnt = stall_exp ? ((exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1) : exp_cnt;
        end
        @(posedge clk);
        #1;
        if (rst) model_known = 1'b1;
        exp_e   = nxt;
        exp_cnt = nxt_cnt;
        if (model_known) begin
            check("ex_bundle", obs, exp_e);
            check("valid_e", valid_e, exp_e.valid);
            check("bubble_cnt", bubble_cnt, exp_cnt);
        end
    endtask

    initial begin
        bundle_t add_i;

        // 1) Reset for two cycles with random ID contents.
        rst = 1'b1;
        din = rand_bundle();
        cycle();
        din = rand_bundle();
        cycle();
        check("rst_valid_e", valid_e, 1'b0);
        check("rst_stall_f", stall_f, 1'b0);
        check("rst_cnt", bubble_cnt, 0);
        rst = 1'b0;

        // 2) ALU producer followed by consumer: no stall, consumer lands one cycle later.
        din = instr(1'b1, 2'b00, 5'd1, 5'd2, 5'd5);
        cycle();
        add_i = instr(1'b1, 2'b00, 5'd5, 5'd3, 5'd7);
        din = add_i;
        cycle();
        check("t2_sub_in_ex", obs, add_i);

        // 3) Load x5 then add using rs2=5: one stall, one bubble, then the add.
        din = instr(1'b1, 2'b01, 5'd1, 5'd0, 5'd5);
        cycle();
        add_i = instr(1'b1, 2'b00, 5'd4, 5'd5, 5'd8);
        din = add_i;
        #1;
        check("t3_stall_f", stall_f, 1'b1);
        cycle();
        check("t3_bubble", valid_e, 1'b0);
        cycle();
        check("t3_add_in_ex", obs, add_i);
        check("t3_cnt", bubble_cnt, 1);

        // 4) Load to x0 never stalls; neither does an invalid ID slot.
        din = instr(1'b1, 2'b01, 5'd1, 5'd0, 5'd0);
        cycle();
        din = instr(1'b1, 2'b00, 5'd0, 5'd0, 5'd9);
        cycle();
        din = instr(1'b1, 2'b01, 5'd1, 5'd2, 5'd5);
        cycle();
        din = instr(1'b1, 2'b00, 5'd5, 5'd5, 5'd9);
        din.valid = 1'b0;
        #1;
        check("t4_invalid_no_stall", stall_d, 1'b0);
        cycle();

        // 5) Load-use coinciding with a flush: bubble, no stall, count unchanged.
        din = instr(1'b1, 2'b01, 5'd1, 5'd2, 5'd6);
        cycle();
        din = instr(1'b1, 2'b00, 5'd6, 5'd1, 5'd9);
        flush_e = 1'b1;
        cycle();
        flush_e = 1'b0;
        check("t5_cnt_hold", bubble_cnt, 1);

        // Back-to-back loads: the second advances after exactly one bubble.
        din = instr(1'b1, 2'b01, 5'd1, 5'd2, 5'd5);
        cycle();
        add_i = instr(1'b1, 2'b01, 5'd5, 5'd0, 5'd6);
        din = add_i;
        cycle();
        cycle();
        check("b2b_load_in_ex", obs, add_i);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 300; i++) begin
            din     = rand_bundle();
            flush_e = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush_e = 1'b0;
        rst     = 1'b0;

        // 6) Drive the counter well past saturation.
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            din = instr(1'b1, 2'b01, 5'd1, 5'd2, 5'd7);
            cycle();
            din = instr(1'b0, 2'b00, 5'd7, 5'd3, 5'd0);
            cycle();
            cycle();
        end
        check("t6_saturated", bubble_cnt, CNT_MAX);

        // Reset asserted during a stall clears everything on the next edge.
        din = instr(1'b1, 2'b01, 5'd1, 5'd2, 5'd7);
        cycle();
        din = instr(1'b1, 2'b00, 5'd7, 5'd7, 5'd3);
        rst = 1'b1;
        #1;
        check("t6_stall_before_rst", stall_f, 1'b1);
        cycle();
        check("t6_rst_bundle", obs, 0);
        check("t6_rst_cnt", bubble_cnt, 0);
        rst = 1'b0;
        din = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
